lpc_capture_ctrl: RTL and testbench

// - Capture sequencer between bufferdomain and ringbuffer, all in the ext_clock domain.
// - Filters decoded LPC records by cycle type and runs an arm/trigger/stop capture sequence.
// - Gates ringbuffer write_clock_enable and counts records dropped while the ringbuffer is full.

---
 rtl/lpc_capture_ctrl_if.sv | 21 ++
 rtl/lpc_capture_ctrl.sv | 131 +++++++++++++
 tb/tb_lpc_capture_ctrl.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/lpc_capture_ctrl_if.sv
// Record bus between bufferdomain, the capture sequencer and the ringbuffer.
// master drives incoming records and full; slave is the capture controller.
interface lpc_capture_ctrl_if #(
    parameter int DW = 48
);
    logic [DW-1:0] in_data;
    logic          in_enable;
    logic          full;
    logic [DW-1:0] out_data;
    logic          out_enable;

    modport master (
        output in_data, in_enable, full,
        input  out_data, out_enable
    );

    modport slave (
        input  in_data, in_enable, full,
        output out_data, out_enable
    );
endinterface

// File: rtl/lpc_capture_ctrl.sv
// LPC capture sequencer: cycle-type filter, arm/trigger/stop, full-drop counting.
// Define LPC_CAPTURE_MARKER_EN to emit a marker record on every entry to STOPPED.
module lpc_capture_ctrl #(
    parameter int          DW         = 48,
    parameter logic [15:0] CYC_MASK   = 16'hFFFF,
    parameter logic [31:0] TRIG_ADDR  = 32'h0000_0080,
    parameter logic [7:0]  TRIG_DATA  = 8'h34,
    parameter logic [3:0]  TRIG_CYC   = 4'b0010,
    parameter logic [15:0] POST_COUNT = 16'd512
) (
    input  logic                clock,
    input  logic                reset,
    lpc_capture_ctrl_if.slave   bus,
    input  logic                arm,
    input  logic                stop,
    output logic [1:0]          state,
    output logic                triggered,
    output logic [15:0]         drop_count
);

`ifdef LPC_CAPTURE_MARKER_EN
    localparam bit MARK_EN = 1'b1;
`else
    localparam bit MARK_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARMED     = 2'd1,
        TRIGGERED = 2'd2,
        STOPPED   = 2'd3
    } state_t;

    state_t        st_q, st_d;
    logic          trig_q, trig_d;
    logic [15:0]   drop_q, drop_d;
    logic [15:0]   post_q, post_d;
    logic          oe_q, oe_d;
    logic [DW-1:0] od_q, od_d;
    logic          pend_q, pend_d;

    logic [3:0] cyc;
    logic       trig_hit;
    logic       acc;
    logic       live;
    logic [7:0] mark_cnt;
    logic       unused_bits;

    assign cyc      = bus.in_data[3:0];
    assign trig_hit = (bus.in_data[47:16] == TRIG_ADDR) &&
                      (bus.in_data[15:8] == TRIG_DATA) &&
                      (cyc == TRIG_CYC);
    assign acc      = bus.in_enable && (CYC_MASK[cyc] || trig_hit);
    assign live     = (st_q == ARMED) || (st_q == TRIGGERED);
    assign mark_cnt = (drop_q[15:8] != 8'h00) ? 8'hFF : drop_q[7:0];
    assign unused_bits = ^bus.in_data[7:4];

    always_ff @(posedge clock) begin
        if (reset) begin
            st_q   <= IDLE;
            trig_q <= 1'b0;
            drop_q <= 16'h0000;
            post_q <= 16'h0000;
            oe_q   <= 1'b0;
            od_q   <= '0;
            pend_q <= 1'b0;
        end else begin
            st_q   <= st_d;
            trig_q <= trig_d;
            drop_q <= drop_d;
            post_q <= post_d;
            oe_q   <= oe_d;
            od_q   <= od_d;
            pend_q <= pend_d;
        end
    end

    always_comb begin
        st_d   = st_q;
        trig_d = trig_q;
        drop_d = drop_q;
        post_d = post_q;
        oe_d   = 1'b0;
        od_d   = od_q;
        pend_d = 1'b0;

        // Marker slot is always free: STOPPED writes nothing, arm discards its strobe.
        if (MARK_EN && pend_q && !bus.full) begin
            oe_d = 1'b1;
            od_d = '0;
            od_d[47:0] = {32'hFFFF_FFFF, mark_cnt, 4'h0, 4'hF};
        end

        if (stop) begin
            if (live) begin
                st_d   = STOPPED;
                pend_d = 1'b1;
            end
        end else if (arm) begin
            st_d   = ARMED;
            trig_d = 1'b0;
            drop_d = 16'h0000;
            post_d = 16'h0000;
        end else if (live && acc) begin
            if (bus.full) begin
                if (drop_q != 16'hFFFF)
                    drop_d = drop_q + 16'd1;
            end else begin
                oe_d = 1'b1;
                od_d = bus.in_data;
            end
            if (st_q == TRIGGERED) begin
                post_d = post_q + 16'd1;
                if (POST_COUNT != 16'd0 && post_d == POST_COUNT) begin
                    st_d   = STOPPED;
                    pend_d = 1'b1;
                end
            end else if (trig_hit) begin
                st_d   = TRIGGERED;
                trig_d = 1'b1;
            end
        end
    end

    assign bus.out_data   = od_q;
    assign bus.out_enable = oe_q;
    assign state          = st_q;
    assign triggered      = trig_q;
    assign drop_count     = drop_q;

endmodule

// File: tb/tb_lpc_capture_ctrl.sv
// Randomized bench for lpc_capture_ctrl with a behavioural reference model.
// Honours LPC_CAPTURE_MARKER_EN the same way as the design.
module tb_lpc_capture_ctrl;

`ifdef LPC_CAPTURE_MARKER_EN
    localparam bit MARK = 1'b1;
`else
    localparam bit MARK = 1'b0;
`endif

    localparam logic [15:0] MASK = 16'h0005;
    localparam logic [31:0] TA   = 32'h0000_0080;
    localparam logic [7:0]  TD   = 8'h34;
    localparam logic [3:0]  TC   = 4'h3;
    localparam int          PC   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        arm = 1'b0;
    logic        stop = 1'b0;
    logic [1:0]  st;
    logic        trig;
    logic [15:0] drop;

    lpc_capture_ctrl_if #(.DW(48)) bus ();

    lpc_capture_ctrl #(
        .DW(48), .CYC_MASK(MASK), .TRIG_ADDR(TA),
        .TRIG_DATA(TD), .TRIG_CYC(TC), .POST_COUNT(16'(PC))
    ) dut (
        .clock(clk), .reset(rst), .bus(bus),
        .arm(arm), .stop(stop), .state(st),
        .triggered(trig), .drop_count(drop)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    bit chk_on = 1'b0;

    task automatic cmp(input string n, input logic [47:0] act, input logic [47:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad < 40)
                $display("FAIL %s: got %h want %h at %0t", n, act, exp, $time);
        end
    endtask

    function automatic logic [47:0] rec(input logic [31:0] a, input logic [7:0] d, input logic [3:0] c);
        return {a, d, 4'h0, c};
    endfunction

    // Reference model: phase 0 idle, 1 armed, 2 after trigger, 3 stopped.
    int          m_st, m_drop, m_post;
    bit          m_trig, m_oe, m_pend;
    logic [47:0] m_od;

    always @(posedge clk) begin
        if (rst) begin
            m_st = 0; m_trig = 0; m_drop = 0; m_post = 0;
            m_oe = 0; m_od = '0; m_pend = 0;
        end else begin
            bit hit, acc, pend_n;
            logic [47:0] d;
            d = bus.in_data;
            hit = d[47:16] == TA && d[15:8] == TD && d[3:0] == TC;
            acc = bus.in_enable && (MASK[d[3:0]] || hit);
            pend_n = 0;
            m_oe = 0;
            if (MARK && m_pend && !bus.full) begin
                m_oe = 1;
                m_od = {32'hFFFF_FFFF, (m_drop > 255) ? 8'hFF : 8'(m_drop), 8'h0F};
            end
            if (stop) begin
                if (m_st == 1 || m_st == 2) begin
                    m_st = 3;
                    pend_n = 1;
                end
            end else if (arm) begin
                m_st = 1; m_drop = 0; m_post = 0; m_trig = 0;
            end else if ((m_st == 1 || m_st == 2) && acc) begin
                if (bus.full) m_drop = (m_drop < 65535) ? m_drop + 1 : 65535;
                else begin
                    m_oe = 1;
                    m_od = d;
                end
                if (m_st == 2) begin
                    m_post = (m_post + 1) % 65536;
                    if (PC != 0 && m_post == PC) begin
                        m_st = 3;
                        pend_n = 1;
                    end
                end else if (hit) begin
                    m_st = 2;
                    m_trig = 1;
                end
            end
            m_pend = pend_n;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            cmp("state", 48'(st), 48'(m_st));
            cmp("triggered", 48'(trig), 48'(m_trig));
            cmp("drop_count", 48'(drop), 48'(m_drop));
            cmp("out_enable", 48'(bus.out_enable), 48'(m_oe));
            cmp("out_data", bus.out_data, m_od);
        end
    end

    task automatic drv(input bit e, input logic [47:0] d, input bit a, input bit s, input bit f);
        @(negedge clk);
        bus.in_enable = e;
        bus.in_data = d;
        arm = a;
        stop = s;
        bus.full = f;
    endtask

    task automatic idle();
        drv(0, 48'h0, 0, 0, 0);
    endtask

    task automatic send(input logic [47:0] d, input bit f);
        drv(1, d, 0, 0, f);
        idle();
    endtask

    initial begin
        logic [47:0] r;
        bit pe;
        bus.in_enable = 0;
        bus.in_data = '0;
        bus.full = 0;
        repeat (2) @(negedge clk);
        cmp("rst_state", 48'(st), 48'd0);
        cmp("rst_oe", 48'(bus.out_enable), 48'd0);
        cmp("rst_od", bus.out_data, 48'd0);
        cmp("rst_trig", 48'(trig), 48'd0);
        cmp("rst_drop", 48'(drop), 48'd0);
        chk_on = 1;
        rst = 0;

        drv(0, 0, 1, 0, 0); idle();
        cmp("arm_state", 48'(st), 48'd1);
        for (int k = 0; k < 3; k++) begin
            r = rec(32'h100 + k, 8'h11, 4'h0);
            send(r, 0);
            cmp("cyc0_oe", 48'(bus.out_enable), 48'd1);
            cmp("cyc0_od", bus.out_data, r);
        end
        cmp("pre_state", 48'(st), 48'd1);
        send(rec(32'h200, 8'h22, 4'h1), 0);
        cmp("filt_oe", 48'(bus.out_enable), 48'd0);

        r = rec(TA, TD, TC);
        send(r, 0);
        cmp("trig_oe", 48'(bus.out_enable), 48'd1);
        cmp("trig_od", bus.out_data, r);
        cmp("trig_state", 48'(st), 48'd2);
        cmp("trig_lvl", 48'(trig), 48'd1);
        send(rec(32'h300, 8'h33, 4'h0), 0);
        cmp("post1_oe", 48'(bus.out_enable), 48'd1);
        send(rec(32'h301, 8'h33, 4'h2), 0);
        cmp("post2_oe", 48'(bus.out_enable), 48'd1);
        cmp("post_state", 48'(st), 48'd3);
        idle();
        send(rec(32'h302, 8'h33, 4'h0), 0);
        cmp("stopped_oe", 48'(bus.out_enable), 48'd0);

        drv(0, 0, 1, 0, 0); idle();
        for (int k = 0; k < 5; k++) begin
            send(rec(32'h400 + k, 8'h44, 4'h0), 1);
            cmp("full_oe", 48'(bus.out_enable), 48'd0);
        end
        cmp("drop5", 48'(drop), 48'd5);
        drv(0, 0, 1, 0, 0); idle();
        cmp("rearm_drop", 48'(drop), 48'd0);
        cmp("rearm_state", 48'(st), 48'd1);

        send(rec(32'h500, 8'h55, 4'h2), 1);
        send(rec(32'h501, 8'h55, 4'h2), 1);
        drv(0, 0, 1, 1, 0); idle();
        cmp("armstop_state", 48'(st), 48'd3);
        cmp("armstop_drop", 48'(drop), 48'd2);
        idle();
        drv(0, 0, 1, 0, 0); idle();
        drv(1, rec(32'h600, 8'h66, 4'h0), 0, 1, 0); idle();
        cmp("stopen_oe", 48'(bus.out_enable), 48'd0);
        cmp("stopen_state", 48'(st), 48'd3);
        idle();

        drv(0, 0, 1, 0, 0); idle();
        for (int k = 0; k < 300; k++) send(rec(32'h700, 8'h77, 4'h0), 1);
        cmp("drop300", 48'(drop), 48'd300);
        drv(0, 0, 0, 1, 0); idle();
        cmp("mk_state", 48'(st), 48'd3);
        cmp("mk_pre_oe", 48'(bus.out_enable), 48'd0);
        idle();
        if (MARK) begin
            cmp("mk_oe", 48'(bus.out_enable), 48'd1);
            cmp("mk_od", bus.out_data, 48'hFFFF_FFFF_FF0F);
        end else begin
            cmp("nomk_oe", 48'(bus.out_enable), 48'd0);
        end

        pe = 0;
        for (int i = 0; i < 4000; i++) begin
            int rr;
            bit e;
            rr = int'($urandom_range(0, 999));
            e = !pe && ($urandom_range(0, 9) < 4);
            case ($urandom_range(0, 3))
                0: r = rec(TA, TD, TC);
                1: r = rec(TA, 8'($urandom), 4'($urandom_range(0, 4)));
                default: r = rec(32'($urandom_range(0, 255)), 8'($urandom),
                                 4'($urandom_range(0, 4)));
            endcase
            @(negedge clk);
            rst = (rr < 3);
            arm = (rr >= 3 && rr < 30);
            stop = (rr >= 25 && rr < 45);
            bus.full = ($urandom_range(0, 3) == 0);
            bus.in_enable = e;
            bus.in_data = r;
            pe = e;
        end
        rst = 0;
        idle(); idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
